// File: rtl/qenc_pkg.sv
// Shared types and constants for the quadrature encoder emulator.
// The bounce constants are only consumed when QENC_BOUNCE_EN is defined.
package qenc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Entry i (bits [2i+1:2i]) is {A,B} for phase index i: 00, 10, 11, 01.
  localparam logic [7:0] GRAY_LUT = 8'b01_11_10_00;

  localparam int BOUNCE_CYC        = 3;
  localparam int MIN_PERIOD_BOUNCE = 4;

  function automatic logic [1:0] gray_ab(input logic [1:0] phase);
    return GRAY_LUT[{phase, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/qenc_timer.sv
// Quarter-phase timer: loadable down-counter that pulses expire on its last
// count and reloads itself from the latched period while run stays high.
module qenc_timer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             run,
  input  logic [CNT_W-1:0] period,
  output logic             expire
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] reload;

  // A count of 0 can only be seen before the first load; treat it as expired.
  assign expire = run && (count <= CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= '0;
      reload <= '0;
    end else if (load) begin
      count  <= period;
      reload <= period;
    end else if (run) begin
      if (expire) count <= reload;
      else        count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: turns step commands into A/B Gray-code edges.
// Define QENC_BOUNCE_EN to add contact-bounce emulation on each changing channel.
module quad_encoder_gen
  import qenc_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              enc_a,
  output logic              enc_b,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left,
  output state_e            state
);

  // Handshake: a command transfers on a clock edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high exactly while the block is IDLE.

  state_e            state_n;
  logic [1:0]        phase, phase_n;
  logic              dir_q, dir_n;
  logic [STEP_W-1:0] steps_n;
  logic              done_n;
  logic              load;
  logic              adv;
  logic              expire;
  logic              timer_run;
  logic [CNT_W-1:0]  eff_period;
  logic [1:0]        ab_n;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign timer_run = (state == RUN) && !abort;

  always_comb begin
    eff_period = cmd_period;
`ifdef QENC_BOUNCE_EN
    // Bounce needs BOUNCE_CYC cycles to settle before the next edge.
    if (cmd_period < CNT_W'(MIN_PERIOD_BOUNCE)) eff_period = CNT_W'(MIN_PERIOD_BOUNCE);
`else
    if (cmd_period == '0) eff_period = CNT_W'(1);
`endif
  end

  qenc_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (load),
    .run    (timer_run),
    .period (eff_period),
    .expire (expire)
  );

  always_comb begin
    state_n = state;
    phase_n = phase;
    dir_n   = dir_q;
    steps_n = steps_left;
    done_n  = 1'b0;
    load    = 1'b0;
    adv     = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          dir_n = cmd_dir;
          if (cmd_steps != '0) begin
            state_n = RUN;
            load    = 1'b1;
            steps_n = cmd_steps;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      RUN: begin
        // Abort has priority over a coincident timer expiry.
        if (abort) begin
          state_n = IDLE;
          steps_n = '0;
        end else if (expire) begin
          adv     = 1'b1;
          phase_n = dir_q ? phase + 2'd1 : phase - 2'd1;
          steps_n = steps_left - STEP_W'(1);
          if (steps_left <= STEP_W'(1)) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef QENC_BOUNCE_EN
  logic [1:0] bcnt, bcnt_n;
  logic [1:0] mask, mask_n;

  // bcnt runs 3,2,1,0 after an edge; the count of 2 shows the old level.
  always_comb begin
    bcnt_n = bcnt;
    mask_n = mask;
    if (adv) begin
      bcnt_n = 2'(BOUNCE_CYC);
      mask_n = gray_ab(phase) ^ gray_ab(phase_n);
    end else if (bcnt != 2'd0) begin
      bcnt_n = bcnt - 2'd1;
    end
    ab_n = gray_ab(phase_n);
    if (bcnt_n == 2'd2) ab_n = ab_n ^ mask_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bcnt <= 2'd0;
      mask <= 2'd0;
    end else begin
      bcnt <= bcnt_n;
      mask <= mask_n;
    end
  end
`else
  always_comb begin
    ab_n = gray_ab(phase_n);
  end
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= 2'd0;
      dir_q      <= 1'b0;
      steps_left <= '0;
      done       <= 1'b0;
      enc_a      <= 1'b0;
      enc_b      <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      dir_q      <= dir_n;
      steps_left <= steps_n;
      done       <= done_n;
      enc_a      <= ab_n[1];
      enc_b      <= ab_n[0];
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: a phase model predicts every A/B
// change, steps_left value and done pulse; a monitor pops and compares them.
module tb_quad_encoder_gen;
  import qenc_pkg::*;

  localparam int CNT_W  = 16;
  localparam int STEP_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_dir = 1'b0;
  logic              abort = 1'b0;
  logic [STEP_W-1:0] cmd_steps = '0;
  logic [CNT_W-1:0]  cmd_period = '0;
  logic              cmd_ready, enc_a, enc_b, busy, done;
  logic [STEP_W-1:0] steps_left;
  state_e            state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [1:0] m_phase = 2'd0;
  logic [1:0] prev_ab = 2'b00;
  logic [1:0] cur_ab;
  logic       mute = 1'b1;

  logic [1:0] exp_q[$];
  int         exp_cyc_q[$];
  int         exp_sl_q[$];
  int         exp_done_q[$];

  logic [1:0] e_ab;
  int         e_cyc, e_sl, e_done;

  quad_encoder_gen #(.CNT_W(CNT_W), .STEP_W(STEP_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_steps (cmd_steps),
    .cmd_period(cmd_period),
    .abort     (abort),
    .enc_a     (enc_a),
    .enc_b     (enc_b),
    .busy      (busy),
    .done      (done),
    .steps_left(steps_left),
    .state     (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [1:0] model_ab(input logic [1:0] ph);
    case (ph)
      2'd0:    return 2'b00;
      2'd1:    return 2'b10;
      2'd2:    return 2'b11;
      default: return 2'b01;
    endcase
  endfunction

  function automatic int eff_p(input int period);
    int p;
    p = (period == 0) ? 1 : period;
`ifdef QENC_BOUNCE_EN
    if (p < 4) p = 4;
`endif
    return p;
  endfunction

  task automatic clear_model();
    exp_q.delete();
    exp_cyc_q.delete();
    exp_sl_q.delete();
    exp_done_q.delete();
    m_phase = 2'd0;
  endtask

  task automatic do_reset();
    mute      = 1'b1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    reset_n   = 1'b0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mute = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge clk) begin
    #1;
    cur_ab = {enc_a, enc_b};
    if (reset_n === 1'b1 && !mute) begin
      if (cur_ab !== prev_ab) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL ab_unexpected cyc=%0d got=%b prev=%b", cyc, cur_ab, prev_ab);
        end else begin
          e_ab  = exp_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          e_sl  = exp_sl_q.pop_front();
          if (cur_ab !== e_ab || cyc != e_cyc) begin
            errors++;
            $display("FAIL ab_change got=%b at cyc %0d, want=%b at cyc %0d", cur_ab, cyc, e_ab, e_cyc);
          end
          if (e_sl >= 0) begin
            checks++;
            if (steps_left !== e_sl[STEP_W-1:0]) begin
              errors++;
              $display("FAIL steps_left cyc=%0d got=%0d want=%0d", cyc, steps_left, e_sl);
            end
          end
        end
      end
      if (done !== 1'b0) begin
        checks++;
        if (exp_done_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected cyc=%0d done=%b", cyc, done);
        end else begin
          e_done = exp_done_q.pop_front();
          if (done !== 1'b1 || cyc != e_done) begin
            errors++;
            $display("FAIL done_timing got=%b at cyc %0d, want=1 at cyc %0d", done, cyc, e_done);
          end
        end
      end
    end
    prev_ab = cur_ab;
  end

  // ---------------- driver tasks ----------------
  // Offers a command, predicts its A/B edges, returns the accept cycle.
  // abort_at > 0 drops every edge at or after accept+abort_at and the done pulse.
  task automatic send_cmd(input logic dir, input int steps, input int period,
                          input int abort_at, output int t0);
    int p;
    int g;
    p          = eff_p(period);
    cmd_valid  = 1'b1;
    cmd_dir    = dir;
    cmd_steps  = steps[STEP_W-1:0];
    cmd_period = period[CNT_W-1:0];
    g = 0;
    while (cmd_ready !== 1'b1 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cmd_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout cmd_ready=%b want=1", cmd_ready);
      cmd_valid = 1'b0;
      t0 = -1;
      return;
    end
    t0 = cyc + 1;
    for (int k = 1; k <= steps; k++) begin
      logic [1:0] old_ab;
      if (abort_at > 0 && k * p >= abort_at) break;
      old_ab  = model_ab(m_phase);
      m_phase = dir ? m_phase + 2'd1 : m_phase - 2'd1;
      exp_q.push_back(model_ab(m_phase));
      exp_cyc_q.push_back(t0 + k * p);
      exp_sl_q.push_back(steps - k);
`ifdef QENC_BOUNCE_EN
      exp_q.push_back(old_ab);
      exp_cyc_q.push_back(t0 + k * p + 1);
      exp_sl_q.push_back(-1);
      exp_q.push_back(model_ab(m_phase));
      exp_cyc_q.push_back(t0 + k * p + 2);
      exp_sl_q.push_back(-1);
`endif
    end
    if (abort_at == 0) exp_done_q.push_back(t0 + steps * p);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || exp_done_q.size() != 0 || cmd_ready !== 1'b1) && g < 500) begin
      @(posedge clk);
      #2;
      g++;
    end
    checks++;
    if (exp_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending_ab=%0d pending_done=%0d want 0/0", name, exp_q.size(), exp_done_q.size());
      exp_q.delete();
      exp_cyc_q.delete();
      exp_sl_q.delete();
      exp_done_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    #1;
    reset_n = 1'b0;
    #2;
    checks++;
    if ({enc_a, enc_b, cmd_ready, busy, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_async ab/ready/busy/done got=%b want=00100", {enc_a, enc_b, cmd_ready, busy, done});
    end
    do_reset();
    checks++;
    if ({enc_a, enc_b, cmd_ready, busy, done} !== 5'b00100) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00100", {enc_a, enc_b, cmd_ready, busy, done});
    end
    checks++;
    if (steps_left !== '0 || state !== IDLE) begin
      errors++;
      $display("FAIL reset_state steps_left=%0d state=%0d want 0/IDLE", steps_left, state);
    end
  endtask

  task automatic test_cw();
    int t0;
    send_cmd(1'b1, 4, 3, 0, t0);
    checks++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0 || steps_left !== 8'd4) begin
      errors++;
      $display("FAIL cw_accept busy=%b ready=%b steps_left=%0d want 1/0/4", busy, cmd_ready, steps_left);
    end
    wait_drain("cw");
    checks++;
    if (steps_left !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cw_end steps_left=%0d busy=%b want 0/0", steps_left, busy);
    end
  endtask

  task automatic test_ccw();
    int t0;
    int n;
    int g;
    send_cmd(1'b0, 2, 1, 0, t0);
    n = 0;
    g = 0;
    while (cmd_ready !== 1'b1 && g < 200) begin
      n++;
      @(posedge clk);
      #1;
      g++;
    end
    checks++;
    if (n != 2 * eff_p(1)) begin
      errors++;
      $display("FAIL ccw_ready_low cycles got=%0d want=%0d", n, 2 * eff_p(1));
    end
    wait_drain("ccw");
  endtask

  task automatic test_zero_steps();
    int t0;
    int busy_hi;
    send_cmd(1'b1, 0, 5, 0, t0);
    busy_hi = 0;
    for (int i = 0; i < 6; i++) begin
      if (busy !== 1'b0 || cmd_ready !== 1'b1) busy_hi++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (busy_hi != 0) begin
      errors++;
      $display("FAIL zero_busy cycles_busy got=%0d want=0", busy_hi);
    end
    wait_drain("zero");
  endtask

  task automatic test_abort();
    int t0;
    send_cmd(1'b1, 10, 4, 9, t0);
    repeat (8) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if (state !== IDLE || cmd_ready !== 1'b1 || busy !== 1'b0 || steps_left !== '0) begin
      errors++;
      $display("FAIL abort_exit state=%0d ready=%b busy=%b steps_left=%0d want IDLE/1/0/0",
               state, cmd_ready, busy, steps_left);
    end
    wait_drain("abort");
    // Abort held across an IDLE accept must not block the command.
    abort = 1'b1;
    send_cmd(1'b1, 1, 1, 0, t0);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle_accept busy=%b want=1", busy);
    end
    wait_drain("abort_next");
  endtask

  task automatic test_back_to_back();
    int t1;
    int t2;
    send_cmd(1'b1, 3, 2, 0, t1);
    send_cmd(1'b0, 2, 3, 0, t2);
    checks++;
    if (t2 != t1 + 3 * eff_p(2) + 1) begin
      errors++;
      $display("FAIL b2b_accept cyc got=%0d want=%0d", t2, t1 + 3 * eff_p(2) + 1);
    end
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid_run();
    int t0;
    do_reset();
    send_cmd(1'b1, 3, 2, 0, t0);
    repeat (2 * eff_p(2)) @(posedge clk);
    #1;
    checks++;
    if ({enc_a, enc_b} !== 2'b11) begin
      errors++;
      $display("FAIL midrun_ab got=%b want=11", {enc_a, enc_b});
    end
    mute = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({enc_a, enc_b, cmd_ready, busy} !== 4'b0010) begin
      errors++;
      $display("FAIL midrun_async ab/ready/busy got=%b want=0010", {enc_a, enc_b, cmd_ready, busy});
    end
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || state !== IDLE || steps_left !== '0) begin
      errors++;
      $display("FAIL midrun_release ready=%b state=%0d steps_left=%0d want 1/IDLE/0",
               cmd_ready, state, steps_left);
    end
    mute = 1'b0;
    send_cmd(1'b1, 1, 1, 0, t0);
    wait_drain("midrun_after");
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_cw();
    test_ccw();
    test_zero_steps();
    test_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
